apb_gpio_slave: RTL and testbench

- APB completer (slave) for one general-purpose I/O port.
- Sits on one PSELx/PRDATAx/PREADYx slot of the existing APB master, e.g. the 0x1000_1xxx window.
- Provides a direction register, an output data register, a synchronized input data register, and per-bit edge-triggered interrupts with write-1-to-clear status.
- Inserts a programmable number of wait states through PREADY.

---
 rtl/apb_gpio_pkg.sv | 25 ++
 rtl/gpio_sync_edge.sv | 38 +++
 rtl/apb_gpio_slave.sv | 182 ++++++++++++++++++
 tb/tb_apb_gpio_slave.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO completer.
//   apb_state_t : access-phase FSM states (IDLE / WAIT / RESP)
//   *_OFS       : register byte offsets inside the 32-byte window
//   ADDR_IDX_W  : number of decoded word-address bits (PADDR[4:2])
//   CNT_W       : width of the wait-state counter (0..15 wait states)
package apb_gpio_pkg;

  localparam int unsigned ADDR_IDX_W = 3;
  localparam int unsigned OFS_W      = ADDR_IDX_W + 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } apb_state_t;

  localparam logic [OFS_W-1:0] MODER_OFS = 5'h00;
  localparam logic [OFS_W-1:0] IDR_OFS   = 5'h04;
  localparam logic [OFS_W-1:0] ODR_OFS   = 5'h08;
  localparam logic [OFS_W-1:0] IER_OFS   = 5'h0C;
  localparam logic [OFS_W-1:0] EDGE_OFS  = 5'h10;
  localparam logic [OFS_W-1:0] ISR_OFS   = 5'h14;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer for asynchronous pad inputs plus a previous-sample
// register used for per-bit edge detection.
//   clk  : sampling clock
//   rst  : asynchronous, active-high reset (all flops to 0)
//   din  : asynchronous pad inputs
//   sync : synchronized inputs (second synchronizer stage)
//   rise : sync went 0->1 relative to the previous sample
//   fall : sync went 1->0 relative to the previous sample
module gpio_sync_edge #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/apb_gpio_slave.sv
// APB completer for one GPIO port: direction, output data, synchronized
// input data and per-bit edge interrupts with write-1-to-clear status.
// A programmable number of wait states is inserted through PREADY.
//   PCLK, PRESET      : APB clock, asynchronous active-high reset
//   PADDR[4:2]        : register select (other address bits ignored)
//   PWRITE, PSEL,
//   PENABLE, PWDATA   : APB request
//   PRDATA, PREADY    : registered APB response
//   gpio_in           : asynchronous pad inputs
//   gpio_out, gpio_oe : ODR value and MODER value (1 = drive)
//   irq               : registered |(ISR & IER)
module apb_gpio_slave
  import apb_gpio_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [31:0]           PADDR,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  apb_state_t                  state;
  apb_state_t                  state_next;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_next;

  logic [GPIO_WIDTH-1:0]       moder;
  logic [GPIO_WIDTH-1:0]       odr;
  logic [GPIO_WIDTH-1:0]       ier;
  logic [GPIO_WIDTH-1:0]       edge_sel;
  logic [GPIO_WIDTH-1:0]       isr;

  logic [GPIO_WIDTH-1:0]       idr;
  logic [GPIO_WIDTH-1:0]       rise;
  logic [GPIO_WIDTH-1:0]       fall;
  logic [GPIO_WIDTH-1:0]       isr_set;
  logic [GPIO_WIDTH-1:0]       isr_clr;
  logic [GPIO_WIDTH-1:0]       wdata;

  logic [OFS_W-1:0]            ofs;
  logic [31:0]                 rd_data;
  logic                        wr_commit;
  logic                        unused_bits;

  assign ofs         = {PADDR[OFS_W-1:2], 2'b00};
  assign wdata       = PWDATA[GPIO_WIDTH-1:0];
  assign unused_bits = ^{PADDR[31:OFS_W], PADDR[1:0], PWDATA};

  gpio_sync_edge #(
    .WIDTH(GPIO_WIDTH)
  ) u_sync_edge (
    .clk (PCLK),
    .rst (PRESET),
    .din (gpio_in),
    .sync(idr),
    .rise(rise),
    .fall(fall)
  );

  // ---------------------------------------------------------------------
  // Access-phase FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (PSEL && PENABLE) begin
          cnt_next   = WS_LOAD;
          state_next = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // A dropped PSEL mid-access abandons the transfer without effect.
        if (!PSEL) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The master holds address/control through the RESP cycle, so the write
  // commits on the edge that closes it.
  assign wr_commit = (state == RESP) && PWRITE;

  // ---------------------------------------------------------------------
  // Read mux and registered response
  // ---------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    case (ofs)
      MODER_OFS: rd_data = 32'(moder);
      IDR_OFS:   rd_data = 32'(idr);
      ODR_OFS:   rd_data = 32'(odr);
      IER_OFS:   rd_data = 32'(ier);
      EDGE_OFS:  rd_data = 32'(edge_sel);
      ISR_OFS:   rd_data = 32'(isr);
      default:   rd_data = '0;
    endcase
  end

  // RESP is only ever entered from IDLE or WAIT and always left after one
  // cycle, so next-state == RESP marks exactly the entry edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
    end else begin
      PREADY <= (state_next == RESP);
      PRDATA <= ((state_next == RESP) && !PWRITE) ? rd_data : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      moder    <= '0;
      odr      <= '0;
      ier      <= '0;
      edge_sel <= '0;
    end else if (wr_commit) begin
      case (ofs)
        MODER_OFS: moder    <= wdata;
        ODR_OFS:   odr      <= wdata;
        IER_OFS:   ier      <= wdata;
        EDGE_OFS:  edge_sel <= wdata;
        default:   ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Interrupt status: set has priority over a same-cycle W1C.
  // ---------------------------------------------------------------------
  assign isr_set = ~moder & ((edge_sel & rise) | (~edge_sel & fall));
  assign isr_clr = (wr_commit && (ofs == ISR_OFS)) ? wdata : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      isr <= '0;
      irq <= 1'b0;
    end else begin
      isr <= (isr & ~isr_clr) | isr_set;
      irq <= |(isr & ier);
    end
  end

  assign gpio_out = odr;
  assign gpio_oe  = moder;

endmodule

// File: tb/tb_apb_gpio_slave.sv
module tb_apb_gpio_slave;

  logic        PCLK;
  logic        PRESET;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic [7:0]  gpio_in;

  logic        psel     [2];
  logic [31:0] prdata   [2];
  logic        pready   [2];
  logic        irq      [2];
  logic [7:0]  gpio_out [2];
  logic [7:0]  gpio_oe  [2];

  int checks = 0;
  int errors = 0;

  // Two instances share the bus except PSEL: index 0 has no wait states,
  // index 1 has three.
  apb_gpio_slave #(.GPIO_WIDTH(8), .WAIT_STATES(0)) dut_ws0 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSEL(psel[0]), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .gpio_in(gpio_in),
    .gpio_out(gpio_out[0]), .gpio_oe(gpio_oe[0]), .irq(irq[0])
  );

  apb_gpio_slave #(.GPIO_WIDTH(8), .WAIT_STATES(3)) dut_ws3 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
    .PSEL(psel[1]), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .gpio_in(gpio_in),
    .gpio_out(gpio_out[1]), .gpio_oe(gpio_oe[1]), .irq(irq[1])
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // ---------------------------------------------------------------------
  // Reference model: register contents per instance, a shared view of the
  // pad history (two-sample delayed), and writes posted by the bus task to
  // take effect at the edge that ends the response cycle.
  // ---------------------------------------------------------------------
  logic [7:0] m_moder [2];
  logic [7:0] m_odr   [2];
  logic [7:0] m_ier   [2];
  logic [7:0] m_edge  [2];
  logic [7:0] m_isr   [2];
  logic       m_irq   [2];
  logic       pend_v  [2];
  logic [2:0] pend_a  [2];
  logic [7:0] pend_d  [2];
  logic [7:0] m_s1, m_s2, m_prev;
  logic [7:0] m_set, m_clr;

  initial begin
    forever begin
      @(posedge PCLK);
      if (PRESET) begin
        for (int d = 0; d < 2; d++) begin
          m_moder[d] = '0; m_odr[d] = '0; m_ier[d] = '0; m_edge[d] = '0;
          m_isr[d] = '0; m_irq[d] = 1'b0; pend_v[d] = 1'b0;
        end
        m_s1 = '0; m_s2 = '0; m_prev = '0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          // an input pin flags an event when its synchronized value changed
          // in the direction selected by EDGE
          m_set = '0;
          for (int b = 0; b < 8; b++)
            if (!m_moder[d][b] && (m_s2[b] != m_prev[b]) && (m_s2[b] == m_edge[d][b]))
              m_set[b] = 1'b1;
          m_irq[d] = (m_isr[d] & m_ier[d]) != 8'h00;
          m_clr = '0;
          if (pend_v[d]) begin
            case (pend_a[d])
              3'd0: m_moder[d] = pend_d[d];
              3'd2: m_odr[d]   = pend_d[d];
              3'd3: m_ier[d]   = pend_d[d];
              3'd4: m_edge[d]  = pend_d[d];
              3'd5: m_clr      = pend_d[d];
              default: ;
            endcase
            pend_v[d] = 1'b0;
          end
          m_isr[d] = (m_isr[d] & ~m_clr) | m_set;
        end
        m_prev = m_s2;
        m_s2   = m_s1;
        m_s1   = gpio_in;
      end
    end
  end

  function automatic logic [31:0] model_read(input int d, input logic [2:0] idx);
    case (idx)
      3'd0:    return {24'h0, m_moder[d]};
      3'd1:    return {24'h0, m_s2};
      3'd2:    return {24'h0, m_odr[d]};
      3'd3:    return {24'h0, m_ier[d]};
      3'd4:    return {24'h0, m_edge[d]};
      3'd5:    return {24'h0, m_isr[d]};
      default: return 32'h0;
    endcase
  endfunction

  // One APB transfer on instance d. Observes PREADY per access cycle
  // (bit c-1 for cycle c, up to one cycle past the expected response),
  // PRDATA in the response cycle and OR of PRDATA in all other cycles.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic chg, input logic [7:0] gval,
                          output logic [7:0] rdy_mask, output logic [31:0] rd_resp,
                          output logic [31:0] rd_stray, output logic [31:0] exp_rd);
    int unsigned ws = (d == 0) ? 0 : 3;
    @(posedge PCLK); #1;
    if (chg) gpio_in = gval;
    psel[d] = 1'b1; PADDR = addr; PWRITE = wr; PWDATA = wdata; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    rdy_mask = '0; rd_resp = '0; rd_stray = '0; exp_rd = '0;
    for (int unsigned c = 1; c <= ws + 3; c++) begin
      @(negedge PCLK);
      rdy_mask[c-1] = pready[d];
      if (c == ws + 2) rd_resp = prdata[d];
      else rd_stray = rd_stray | prdata[d];
      if (c == ws + 1) exp_rd = wr ? 32'h0 : model_read(d, addr[4:2]);
      if (c == ws + 2) begin
        if (wr) begin
          pend_v[d] = 1'b1; pend_a[d] = addr[4:2]; pend_d[d] = wdata[7:0];
        end
        @(posedge PCLK); #1;
        psel[d] = 1'b0; PENABLE = 1'b0;
      end
    end
  endtask

  logic [7:0]  rm;
  logic [31:0] rr, rs, er;

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      if (prdata[d] !== 32'h0) begin errors++; $display("FAIL reset_prdata[%0d] got %h want 0", d, prdata[d]); end
      checks++;
      if (pready[d] !== 1'b0) begin errors++; $display("FAIL reset_pready[%0d] got %b want 0", d, pready[d]); end
      checks++;
      if (irq[d] !== 1'b0) begin errors++; $display("FAIL reset_irq[%0d] got %b want 0", d, irq[d]); end
      checks++;
      if (gpio_out[d] !== 8'h00) begin errors++; $display("FAIL reset_gpio_out[%0d] got %h want 0", d, gpio_out[d]); end
      checks++;
      if (gpio_oe[d] !== 8'h00) begin errors++; $display("FAIL reset_gpio_oe[%0d] got %h want 0", d, gpio_oe[d]); end
      checks++;
    end
  endtask

  task automatic test_write_outputs;
    apb_xfer(0, 1'b1, 32'h1000_1008, 32'h0000_00A5, 1'b0, 8'h00, rm, rr, rs, er);
    if (rm !== 8'h02) begin errors++; $display("FAIL odr_pready got %b want %b", rm, 8'h02); end
    checks++;
    if ((rr | rs) !== 32'h0) begin errors++; $display("FAIL odr_prdata got %h want 0", rr | rs); end
    checks++;
    apb_xfer(0, 1'b1, 32'h1000_1000, 32'h0000_00FF, 1'b0, 8'h00, rm, rr, rs, er);
    if (rm !== 8'h02) begin errors++; $display("FAIL moder_pready got %b want %b", rm, 8'h02); end
    checks++;
    if (gpio_out[0] !== m_odr[0]) begin errors++; $display("FAIL gpio_out got %h want %h", gpio_out[0], m_odr[0]); end
    checks++;
    if (gpio_oe[0] !== m_moder[0]) begin errors++; $display("FAIL gpio_oe got %h want %h", gpio_oe[0], m_moder[0]); end
    checks++;
  endtask

  task automatic test_wait_states;
    apb_xfer(1, 1'b1, 32'h1000_1000, 32'h0000_00FF, 1'b0, 8'h00, rm, rr, rs, er);
    if (rm !== 8'h10) begin errors++; $display("FAIL ws_write_pready got %b want %b", rm, 8'h10); end
    checks++;
    apb_xfer(1, 1'b0, 32'h1000_1000, 32'h0, 1'b0, 8'h00, rm, rr, rs, er);
    if (rm !== 8'h10) begin errors++; $display("FAIL ws_read_pready got %b want %b", rm, 8'h10); end
    checks++;
    if (rr !== er) begin errors++; $display("FAIL ws_read_prdata got %h want %h", rr, er); end
    checks++;
    if (rs !== 32'h0) begin errors++; $display("FAIL ws_prdata_outside_resp got %h want 0", rs); end
    checks++;
  endtask

  task automatic test_edge_irq;
    apb_xfer(0, 1'b1, 32'h00, 32'h00, 1'b1, 8'h00, rm, rr, rs, er);
    apb_xfer(0, 1'b1, 32'h10, 32'h01, 1'b0, 8'h00, rm, rr, rs, er);
    apb_xfer(0, 1'b1, 32'h0C, 32'h01, 1'b0, 8'h00, rm, rr, rs, er);
    apb_xfer(0, 1'b1, 32'h14, 32'hFF, 1'b0, 8'h00, rm, rr, rs, er);
    @(posedge PCLK); #1;
    gpio_in = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      @(negedge PCLK);
      if (irq[0] !== m_irq[0]) begin errors++; $display("FAIL rise_irq_cycle%0d got %b want %b", k, irq[0], m_irq[0]); end
      checks++;
    end
    if (irq[0] !== 1'b1) begin errors++; $display("FAIL rise_irq_final got %b want 1", irq[0]); end
    checks++;
    apb_xfer(0, 1'b0, 32'h14, 32'h0, 1'b0, 8'h00, rm, rr, rs, er);
    if (rr !== er) begin errors++; $display("FAIL isr_after_rise got %h want %h", rr, er); end
    checks++;
    apb_xfer(0, 1'b1, 32'h14, 32'h01, 1'b0, 8'h00, rm, rr, rs, er);
    @(negedge PCLK);
    if (irq[0] !== m_irq[0]) begin errors++; $display("FAIL irq_after_w1c got %b want %b", irq[0], m_irq[0]); end
    checks++;
    @(posedge PCLK); #1;
    gpio_in = 8'h00;
    repeat (5) @(negedge PCLK);
    apb_xfer(0, 1'b0, 32'h14, 32'h0, 1'b0, 8'h00, rm, rr, rs, er);
    if (rr !== er) begin errors++; $display("FAIL isr_after_fall got %h want %h", rr, er); end
    checks++;
  endtask

  task automatic test_w1c_race;
    @(posedge PCLK); #1; gpio_in = 8'h01;
    repeat (5) @(negedge PCLK);
    @(posedge PCLK); #1; gpio_in = 8'h00;
    repeat (5) @(negedge PCLK);
    // the new rising edge reaches ISR on the same edge that commits the W1C
    apb_xfer(0, 1'b1, 32'h14, 32'h01, 1'b1, 8'h01, rm, rr, rs, er);
    @(negedge PCLK);
    if (irq[0] !== m_irq[0]) begin errors++; $display("FAIL race_irq got %b want %b", irq[0], m_irq[0]); end
    checks++;
    apb_xfer(0, 1'b0, 32'h14, 32'h0, 1'b0, 8'h00, rm, rr, rs, er);
    if (rr !== er) begin errors++; $display("FAIL race_isr got %h want %h", rr, er); end
    checks++;
    if (rr !== 32'h1) begin errors++; $display("FAIL race_isr_bit0 got %h want 1", rr); end
    checks++;
  endtask

  task automatic test_reset_mid;
    @(posedge PCLK); #1;
    psel[1] = 1'b1; PADDR = 32'h08; PWRITE = 1'b1; PWDATA = 32'h3C; PENABLE = 1'b0;
    @(posedge PCLK); #1; PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    #1;
    if (pready[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_pready got %b want 0", pready[1]); end
    checks++;
    @(posedge PCLK); #1;
    PRESET = 1'b0; psel[1] = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    if (gpio_out[1] !== 8'h00) begin errors++; $display("FAIL rst_mid_odr got %h want 0", gpio_out[1]); end
    checks++;
    apb_xfer(1, 1'b0, 32'h08, 32'h0, 1'b0, 8'h00, rm, rr, rs, er);
    if (rm !== 8'h10) begin errors++; $display("FAIL rst_mid_next_pready got %b want %b", rm, 8'h10); end
    checks++;
    if (rr !== er) begin errors++; $display("FAIL rst_mid_read_odr got %h want %h", rr, er); end
    checks++;
    apb_xfer(1, 1'b1, 32'h08, 32'h3C, 1'b0, 8'h00, rm, rr, rs, er);
    if (gpio_out[1] !== m_odr[1]) begin errors++; $display("FAIL rst_mid_rewrite got %h want %h", gpio_out[1], m_odr[1]); end
    checks++;
  endtask

  task automatic test_unmapped;
    apb_xfer(0, 1'b0, 32'h18, 32'h0, 1'b1, 8'h5A, rm, rr, rs, er);
    if (rr !== er) begin errors++; $display("FAIL read_0x18 got %h want %h", rr, er); end
    checks++;
    apb_xfer(0, 1'b0, 32'h1C, 32'h0, 1'b0, 8'h00, rm, rr, rs, er);
    if (rr !== er) begin errors++; $display("FAIL read_0x1C got %h want %h", rr, er); end
    checks++;
    apb_xfer(0, 1'b1, 32'h04, 32'hFF, 1'b0, 8'h00, rm, rr, rs, er);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 1'b0, 8'h00, rm, rr, rs, er);
    if (rr !== 32'h5A) begin errors++; $display("FAIL idr_write_ignored got %h want %h", rr, 32'h5A); end
    checks++;
    apb_xfer(0, 1'b1, 32'h08, 32'hFFFF_FF3C, 1'b0, 8'h00, rm, rr, rs, er);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 1'b0, 8'h00, rm, rr, rs, er);
    if (rr !== 32'h3C) begin errors++; $display("FAIL odr_upper_bits got %h want %h", rr, 32'h3C); end
    checks++;
  endtask

  task automatic test_random;
    int          d;
    logic [31:0] r, wd, addr;
    logic [2:0]  idx;
    logic        wr, chg;
    logic [7:0]  gv, em;
    for (int i = 0; i < 60; i++) begin
      d   = int'($urandom_range(0, 1));
      r   = $urandom();
      idx = 3'($urandom_range(0, 7));
      addr = {r[31:5], idx, 2'b00};
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom();
      chg = 1'($urandom_range(0, 1));
      gv  = 8'($urandom());
      em  = (d == 0) ? 8'h02 : 8'h10;
      apb_xfer(d, wr, addr, wd, chg, gv, rm, rr, rs, er);
      if (rm !== em) begin errors++; $display("FAIL rnd%0d_pready got %b want %b", i, rm, em); end
      checks++;
      if (rr !== er) begin errors++; $display("FAIL rnd%0d_prdata got %h want %h", i, rr, er); end
      checks++;
      if (rs !== 32'h0) begin errors++; $display("FAIL rnd%0d_prdata_idle got %h want 0", i, rs); end
      checks++;
      if (gpio_out[d] !== m_odr[d]) begin errors++; $display("FAIL rnd%0d_gpio_out got %h want %h", i, gpio_out[d], m_odr[d]); end
      checks++;
      if (gpio_oe[d] !== m_moder[d]) begin errors++; $display("FAIL rnd%0d_gpio_oe got %h want %h", i, gpio_oe[d], m_moder[d]); end
      checks++;
      if (irq[d] !== m_irq[d]) begin errors++; $display("FAIL rnd%0d_irq got %b want %b", i, irq[d], m_irq[d]); end
      checks++;
    end
  endtask

  initial begin
    PRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PENABLE = 1'b0;
    gpio_in = '0; psel[0] = 1'b0; psel[1] = 1'b0;
    for (int d = 0; d < 2; d++) pend_v[d] = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    test_reset();
    test_write_outputs();
    test_wait_states();
    test_edge_irq();
    test_w1c_race();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
